// File: rtl/fir_out_requant.sv
// Output stage of the FIR: decimates, rounds half-up, saturates and buffers
// requantized samples in a show-ahead FIFO with sticky clip/drop flags.
module fir_out_requant #(
    parameter int IN_W  = 65,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [IN_W-1:0]   in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     sat_flag,
    output logic                     ovf_flag,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RS    = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [IN_W:0] RND   = (SHIFT > 0) ? ((IN_W+1)'(1) << RS) : '0;
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [CNT_W-1:0]        dec_cnt;
    logic                    keep;
    logic signed [IN_W:0]    ext;
    logic signed [IN_W:0]    rnd;
    logic signed [IN_W:0]    shf;
    logic [OUT_W-1:0]        q_data;
    logic                    clip;

    logic                    stg_valid;
    logic [OUT_W-1:0]        stg_data;

    logic [OUT_W-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    full;
    logic                    do_rd;
    logic                    do_wr;

    assign keep = in_valid && (dec_cnt == '0);

    // Sign-extend by one bit so the rounding add can never wrap.
    always_comb begin
        ext    = {in_data[IN_W-1], in_data};
        rnd    = ext + RND;
        shf    = rnd >>> SHIFT;
        q_data = shf[OUT_W-1:0];
        clip   = 1'b0;
        if (shf > MAX_V) begin
            q_data = MAX_V[OUT_W-1:0];
            clip   = 1'b1;
        end else if (shf < MIN_V) begin
            q_data = MIN_V[OUT_W-1:0];
            clip   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (in_valid) begin
            if (dec_cnt == CNT_W'(DECIM - 1))
                dec_cnt <= '0;
            else
                dec_cnt <= dec_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            stg_valid <= keep;
            if (keep) begin
                stg_data <= q_data;
                if (clip)
                    sat_flag <= 1'b1;
            end
        end
    end

    // A write into a full FIFO is only accepted when the head leaves on the same edge.
    assign full      = (level == (AW+1)'(DEPTH));
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign do_rd     = out_valid && out_ready;
    assign do_wr     = stg_valid && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= stg_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (stg_valid && full && !do_rd)
                ovf_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: one DECIM=1 instance for rounding, saturation and
// FIFO corner cases, one DECIM=4 instance for decimation.
module tb_fir_out_requant;

    logic clk;
    logic rst;

    logic               in_valid1, out_ready1, out_valid1, sat1, ovf1;
    logic signed [64:0] in_data1;
    logic [15:0]        out_data1;
    logic [3:0]         level1;

    logic               in_valid4, out_ready4, out_valid4, sat4, ovf4;
    logic signed [64:0] in_data4;
    logic [15:0]        out_data4;
    logic [3:0]         level4;

    logic [15:0] q1[$];
    logic [15:0] q4[$];
    logic [15:0] exp_v;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [64:0] din;
        logic [15:0]        dout;
        logic               sat;
    } vec_t;
    vec_t tbl[10];

    fir_out_requant #(.IN_W(65), .OUT_W(16), .SHIFT(15), .DECIM(1), .DEPTH(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .out_ready(out_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .sat_flag(sat1), .ovf_flag(ovf1), .level(level1)
    );

    fir_out_requant #(.IN_W(65), .OUT_W(16), .SHIFT(15), .DECIM(4), .DEPTH(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
        .out_ready(out_ready4), .out_valid(out_valid4), .out_data(out_data4),
        .sat_flag(sat4), .ovf_flag(ovf4), .level(level4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: compare at negedge any transfer that the next rising edge commits.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (out_valid1 && out_ready1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL dut1_unexpected: got %0d expected none", $signed(out_data1));
                end else begin
                    exp_v = q1.pop_front();
                    if (out_data1 !== exp_v) begin
                        bad++;
                        $display("FAIL dut1_data: got %0d expected %0d", $signed(out_data1), $signed(exp_v));
                    end
                end
            end
            if (out_valid4 && out_ready4) begin
                total++;
                if (q4.size() == 0) begin
                    bad++;
                    $display("FAIL dut4_unexpected: got %0d expected none", $signed(out_data4));
                end else begin
                    exp_v = q4.pop_front();
                    if (out_data4 !== exp_v) begin
                        bad++;
                        $display("FAIL dut4_data: got %0d expected %0d", $signed(out_data4), $signed(exp_v));
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic signed [64:0] d, input logic r);
        in_valid1  = v;
        in_data1   = d;
        out_ready1 = r;
        tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (q1.size() != 0 || q4.size() != 0); n++)
            tick();
        repeat (2) tick();
        check("q1_drained", 64'(q1.size()), 64'd0);
        check("q4_drained", 64'(q4.size()), 64'd0);
    endtask

    initial begin
        tbl[0] = '{65'sd16384,       16'sd1,      1'b0};
        tbl[1] = '{65'sd16383,       16'sd0,      1'b0};
        tbl[2] = '{-65'sd16384,      16'sd0,      1'b0};
        tbl[3] = '{-65'sd16385,      -16'sd1,     1'b0};
        tbl[4] = '{65'sd1073725439,  16'sd32767,  1'b0};
        tbl[5] = '{-65'sd1073741824, -16'sd32768, 1'b0};
        tbl[6] = '{65'sd3276800,     16'sd100,    1'b0};
        tbl[7] = '{65'sd1073725440,  16'sd32767,  1'b1};
        tbl[8] = '{65'sd1073741824,  16'sd32767,  1'b1};
        tbl[9] = '{-65'sd1099511627776, -16'sd32768, 1'b1};

        rst = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid1), 64'd0);
        check("rst_out_data",  64'(out_data1),  64'd0);
        check("rst_level",     64'(level1),     64'd0);
        check("rst_sat",       64'(sat1),       64'd0);
        check("rst_ovf",       64'(ovf1),       64'd0);
        check("rst_level4",    64'(level4),     64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Rounding and saturation vectors, sat_flag checked as a sticky value.
        for (int i = 0; i < 10; i++) begin
            q1.push_back(tbl[i].dout);
            drive1(1'b1, tbl[i].din, 1'b1);
            in_valid1 = 1'b0;
            repeat (3) tick();
            check("sat_flag_vec", 64'(sat1), 64'(tbl[i].sat));
            check("vec_consumed", 64'(q1.size()), 64'd0);
        end

        // Decimation by 4 with random idle gaps that must not advance the counter.
        out_ready4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                in_valid4 = 1'b0;
                in_data4  = 65'($urandom);
                tick();
            end
            if (k == 1 || k == 5)
                q4.push_back(16'(k));
            in_valid4 = 1'b1;
            in_data4  = 65'(k) <<< 15;
            tick();
        end
        in_valid4 = 1'b0;
        drain();
        check("decim_level", 64'(level4), 64'd0);
        check("decim_sat",   64'(sat4),   64'd0);

        // Overflow: 10 samples into a stalled 8-deep FIFO.
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8)
                q1.push_back(16'(k));
            drive1(1'b1, 65'(k) <<< 15, 1'b0);
        end
        drive1(1'b0, '0, 1'b0);
        tick();
        check("ovf_level", 64'(level1), 64'd8);
        check("ovf_flag",  64'(ovf1),   64'd1);
        out_ready1 = 1'b1;
        drain();
        check("ovf_drained_level", 64'(level1), 64'd0);
        check("ovf_sticky",        64'(ovf1),   64'd1);

        // Flags clear only by reset, asynchronously.
        rst = 1'b1;
        #1;
        check("rst_clr_ovf", 64'(ovf1), 64'd0);
        check("rst_clr_sat", 64'(sat1), 64'd0);
        rst = 1'b0;
        tick();

        // Simultaneous read and write at full keeps level at 8 with no drop.
        for (int k = 1; k <= 9; k++) begin
            q1.push_back(16'(k));
            drive1(1'b1, 65'(k) <<< 15, 1'b0);
        end
        check("full_level", 64'(level1), 64'd8);
        for (int k = 10; k <= 20; k++) begin
            q1.push_back(16'(k));
            drive1(1'b1, 65'(k) <<< 15, 1'b1);
            check("rw_full_level", 64'(level1), 64'd8);
            check("rw_full_ovf",   64'(ovf1),   64'd0);
        end
        drive1(1'b0, '0, 1'b1);
        check("rw_last_level", 64'(level1), 64'd8);
        drain();
        check("rw_ovf_end", 64'(ovf1), 64'd0);

        // Reset mid-stream with 5 stored samples and one in the stage register.
        for (int k = 1; k <= 6; k++)
            drive1(1'b1, 65'(k + 30) <<< 15, 1'b0);
        in_valid1 = 1'b0;
        check("pre_rst_level", 64'(level1), 64'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid1), 64'd0);
        check("mid_rst_level",     64'(level1),     64'd0);
        check("mid_rst_out_data",  64'(out_data1),  64'd0);
        rst = 1'b0;
        q1.delete();
        tick();
        q1.push_back(16'd77);
        drive1(1'b1, 65'sd77 <<< 15, 1'b1);
        q1.push_back(16'd88);
        drive1(1'b1, 65'sd88 <<< 15, 1'b1);
        in_valid1 = 1'b0;
        drain();
        check("post_rst_level", 64'(level1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
